fadd_share_ctrl: RTL and testbench

Round-robin scheduler that shares one FP16 adder (half-precision, 1/5/10 format, fixed pipeline latency) between NREQ requesters. It arbitrates operand requests and issues one add per cycle to the adder. It tags each operation with its requester ID and collects results into a credit-protected response FIFO. Sits between vector/accumulate clients and the single shared adder instance.

---
 rtl/fadd_share_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fadd_share_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_share_ctrl.sv
// Round-robin scheduler sharing one pipelined FP16 adder among NREQ requesters, with ID tags
// and a credit-protected response FIFO. Define FADD_SHARE_STATS_EN to add issue/stall counters.
module fadd_share_ctrl #(
  parameter int NREQ       = 4,
  parameter int ADD_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 fadd_vld,
  output logic [15:0]          fadd_a,
  output logic [15:0]          fadd_b,
  input  logic [15:0]          fadd_sum,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_sum,
  input  logic                 rsp_ready
`ifdef FADD_SHARE_STATS_EN
  ,
  output logic [15:0]          stat_issue_cnt,
  output logic [15:0]          stat_stall_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + ADD_LAT + 2) + 1;

  logic [IDW-1:0]  ptr_reg;
  logic [IDW-1:0]  ptr_next;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic            can_issue;
  logic [CW-1:0]   in_flight;
  logic [IDW-1:0]  issue_id_reg;

  logic [ADD_LAT-1:0] tag_vld_reg;
  logic [IDW-1:0]     tag_id_reg [ADD_LAT];

  logic [IDW-1:0]  fifo_id_mem  [FIFO_DEPTH];
  logic [15:0]     fifo_sum_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push;
  logic            pop;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every op that has been granted but not yet popped holds a credit.
  always_comb begin
    in_flight = CW'(fadd_vld);
    for (int i = 0; i < ADD_LAT; i++) begin
      in_flight = in_flight + CW'(tag_vld_reg[i]);
    end
  end

  assign can_issue = (count_reg + in_flight) < CW'(FIFO_DEPTH);

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    if (rst_n && can_issue) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[rr_idx(ptr_reg, i)]) begin
          grant_any = 1'b1;
          grant_id  = rr_idx(ptr_reg, i);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign req_ready[gi] = grant_any && (grant_id == IDW'(gi));
  end

  assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fadd_vld     <= 1'b0;
      fadd_a       <= '0;
      fadd_b       <= '0;
      issue_id_reg <= '0;
      ptr_reg      <= '0;
    end else begin
      fadd_vld <= grant_any;
      if (grant_any) begin
        fadd_a       <= req_a[16*int'(grant_id) +: 16];
        fadd_b       <= req_b[16*int'(grant_id) +: 16];
        issue_id_reg <= grant_id;
        ptr_reg      <= ptr_next;
      end
    end
  end

  // Tag pipe mirrors the adder latency so the ID lines up with fadd_sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_reg <= '0;
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_id_reg[i] <= '0;
      end
    end else begin
      tag_vld_reg[0] <= fadd_vld;
      tag_id_reg[0]  <= issue_id_reg;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_vld_reg[i] <= tag_vld_reg[i-1];
        tag_id_reg[i]  <= tag_id_reg[i-1];
      end
    end
  end

  assign push      = tag_vld_reg[ADD_LAT-1];
  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = fifo_id_mem[rd_ptr_reg];
  assign rsp_sum   = fifo_sum_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_mem[wr_ptr_reg]  <= tag_id_reg[ADD_LAT-1];
      fifo_sum_mem[wr_ptr_reg] <= fadd_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef FADD_SHARE_STATS_EN
  logic [15:0] issue_cnt_reg;
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (grant_any && (issue_cnt_reg != 16'hFFFF)) issue_cnt_reg <= issue_cnt_reg + 1'b1;
      if ((|req_valid) && !can_issue && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stat_issue_cnt = issue_cnt_reg;
  assign stat_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Bench for fadd_share_ctrl: directed phases plus random traffic against a queue-based model;
// an integer-valued FP16 adder model with ADD_LAT latency stands in for the shared adder.
module tb_fadd_share_ctrl;
  localparam int NREQ       = 4;
  localparam int ADD_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 fadd_vld;
  logic [15:0]          fadd_a;
  logic [15:0]          fadd_b;
  logic [15:0]          fadd_sum;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_sum;
  logic                 rsp_ready;
`ifdef FADD_SHARE_STATS_EN
  logic [15:0]          stat_issue_cnt;
  logic [15:0]          stat_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fadd_share_ctrl #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .fadd_vld(fadd_vld), .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_sum(fadd_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready)
`ifdef FADD_SHARE_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FP16 helpers restricted to non-negative integers below 2048 (exactly representable).
  function automatic logic [15:0] fp_enc(input int n);
    int e;
    logic [15:0] r;
    if (n <= 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    r[15]    = 1'b0;
    r[14:10] = 5'(e + 15);
    r[9:0]   = 10'((n << (10 - e)) & 32'h3FF);
    return r;
  endfunction

  function automatic int fp_dec(input logic [15:0] h);
    int e;
    int m;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]) - 15;
    m = int'({1'b1, h[9:0]});
    if (e < 0) return 0;
    if (e >= 10) return m << (e - 10);
    return m >> (10 - e);
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return fp_enc(fp_dec(a) + fp_dec(b));
  endfunction

  logic [15:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= fp_add(fadd_a, fadd_b);
    for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign fadd_sum = add_pipe[ADD_LAT-1];

  typedef struct {
    int          id;
    logic [15:0] sum;
    int          rdy;
  } ent_t;

  ent_t        q[$];
  int          ptr_m, outst, cyc, gid;
  logic        exp_fvld;
  logic [15:0] exp_fa, exp_fb;
  int          st_issue, st_stall;
  logic [15:0] ra [NREQ];
  logic [15:0] rb [NREQ];
  bit          fixed_ops;
  int          glog[$];
  logic [15:0] poplog[$];
  int          dut_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
    ra[k] = a;
    rb[k] = b;
    req_a[16*k +: 16] = a;
    req_b[16*k +: 16] = b;
  endtask

  task automatic new_ops(input int k);
    if (fixed_ops) set_ops(k, 16'h3C00, 16'h3C00);
    else set_ops(k, fp_enc(int'($urandom_range(1000, 0))), fp_enc(int'($urandom_range(1000, 0))));
  endtask

  // One clock: check outputs against the model, log what the DUT did, advance the model.
  task automatic tick();
    int k;
    int dg;
    logic [NREQ-1:0] eg;
    logic erv;
    ent_t e;
    #1;
    gid = -1;
    if (rst_n && outst < FIFO_DEPTH) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (ptr_m + i) % NREQ;
        if (gid < 0 && req_valid[k]) gid = k;
      end
    end
    eg = '0;
    if (gid >= 0) eg[gid] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("fadd_vld", 32'(fadd_vld), 32'(exp_fvld));
    chk("fadd_a", 32'(fadd_a), 32'(exp_fa));
    chk("fadd_b", 32'(fadd_b), 32'(exp_fb));
    erv = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    if (erv) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
    end
`ifdef FADD_SHARE_STATS_EN
    chk("stat_issue", 32'(stat_issue_cnt), 32'(st_issue));
    chk("stat_stall", 32'(stat_stall_cnt), 32'(st_stall));
`endif
    dg = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) dg = i;
    if (dg >= 0) begin
      glog.push_back(dg);
      dut_hs++;
    end
    if (rst_n && rsp_valid && rsp_ready) poplog.push_back(rsp_sum);

    if (!rst_n) begin
      q.delete();
      outst = 0; ptr_m = 0; exp_fvld = 1'b0; exp_fa = '0; exp_fb = '0;
      st_issue = 0; st_stall = 0;
    end else begin
      if ((|req_valid) && outst >= FIFO_DEPTH && st_stall < 65535) st_stall++;
      if (erv && rsp_ready) begin
        void'(q.pop_front());
        outst--;
      end
      exp_fvld = (gid >= 0);
      if (gid >= 0) begin
        e.id = gid; e.sum = fp_add(ra[gid], rb[gid]); e.rdy = cyc + ADD_LAT + 2;
        q.push_back(e);
        outst++;
        ptr_m = (gid + 1) % NREQ;
        exp_fa = ra[gid]; exp_fb = rb[gid];
        if (st_issue < 65535) st_issue++;
      end
    end
    cyc++;
    @(negedge clk);
    if (gid >= 0) new_ops(gid);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0; fixed_ops = 1'b0;
    req_a = '0; req_b = '0;
    for (int k = 0; k < NREQ; k++) new_ops(k);
    q.delete(); outst = 0; ptr_m = 0; cyc = 0; gid = -1;
    exp_fvld = 1'b0; exp_fa = '0; exp_fb = '0; st_issue = 0; st_stall = 0; dut_hs = 0;
    @(negedge clk);
    tick();  // reset state, req_ready must stay 0 with all requesters valid

    // Single op: 1.0 + 2.0 = 3.0
    rst_n = 1'b1; rsp_ready = 1'b1;
    set_ops(0, 16'h3C00, 16'h4000);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (3) tick();
    #1;
    chk("single_vld", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_sum", 32'(rsp_sum), 32'h4200);
    drain();

    // All requesters valid: grants rotate
    glog.delete();
    req_valid = '1;
    repeat (16) tick();
    req_valid = '0;
    chk("rr_some", 32'(glog.size() >= 8), 32'd1);
    for (int i = 1; i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'((glog[i-1] + 1) % NREQ));
    drain();

    // Backpressure: exactly FIFO_DEPTH handshakes, then drain and resume
    rsp_ready = 1'b0; dut_hs = 0; req_valid = 4'b0100;
    repeat (10) tick();
    chk("bp_hs", 32'(dut_hs), 32'(FIFO_DEPTH));
    rsp_ready = 1'b1; poplog.delete();
    repeat (10) tick();
    chk("bp_resume", 32'(dut_hs > FIFO_DEPTH), 32'd1);
    chk("bp_drained", 32'(poplog.size() >= FIFO_DEPTH), 32'd1);
    drain();

    // Pointer fairness: grant 1 moves ptr to 2, then 1/3 contend
    glog.delete();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    repeat (3) tick();
    req_valid = '0;
    chk("fair_n", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      chk("fair_g1", 32'(glog[1]), 32'd3);
      chk("fair_g2", 32'(glog[2]), 32'd1);
      chk("fair_g3", 32'(glog[3]), 32'd3);
    end
    drain();

    // Reset mid-flight: two ops in the pipe are discarded
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef FADD_SHARE_STATS_EN
    #1;
    chk("rst_stat_issue", 32'(stat_issue_cnt), 32'd0);
    chk("rst_stat_stall", 32'(stat_stall_cnt), 32'd0);
`endif
    seen = 0;
    repeat (8) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("rst_flush", 32'(seen), 32'd0);

    // Wrap-around: 10 ops of 1.0+1.0 with toggling rsp_ready
    fixed_ops = 1'b1;
    for (int k = 0; k < NREQ; k++) new_ops(k);
    poplog.delete(); dut_hs = 0; req_valid = '1;
    for (int n = 0; n < 200 && dut_hs < 10; n++) begin
      rsp_ready = (n % 2 == 0);
      tick();
      if (dut_hs >= 10) req_valid = '0;
    end
    req_valid = '0;
    chk("wrap_hs", 32'(dut_hs), 32'd10);
    rsp_ready = 1'b1;
    repeat (12) tick();
    chk("wrap_pops", 32'(poplog.size()), 32'd10);
    foreach (poplog[i]) chk("wrap_sum", 32'(poplog[i]), 32'h4000);
    fixed_ops = 1'b0;
    for (int k = 0; k < NREQ; k++) new_ops(k);

    // Random traffic; a pending request stays up until granted
    repeat (400) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k]) req_valid[k] = ($urandom_range(1, 0) == 1);
        else if (k == gid) req_valid[k] = ($urandom_range(2, 0) != 0);
      end
      rsp_ready = ($urandom_range(9, 0) < 7);
      tick();
    end
    drain();
    #1;
    chk("final_empty", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
